// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// Shared core types for the hazard controller: register index width, x0 and the scoreboard entry.
// Combinational constants only; no latency or backpressure of its own.
package hazard_scoreboard_ctrl_pkg;

    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] X0 = '0;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              is_load;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_ctrl_if.sv
// ID-stage hazard request/control bundle between decode and the hazard controller.
// Pure wiring; master drives the decode-side inputs, slave returns the pipeline enables.
interface hazard_scoreboard_ctrl_if #(
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 32
);
    logic [NUM_SRC*hazard_scoreboard_ctrl_pkg::REG_AW-1:0] id_rs;
    logic [NUM_SRC-1:0]                                   id_rs_used;
    logic [hazard_scoreboard_ctrl_pkg::REG_AW-1:0]        id_rd;
    logic                                                 id_regwrite;
    logic                                                 id_memread;
    logic                                                 id_is_branch;
    logic                                                 redirect;
    logic                                                 icache_stall;
    logic                                                 dcache_stall;
    logic                                                 pc_stall;
    logic                                                 if_id_stall;
    logic                                                 if_id_flush;
    logic                                                 id_ex_flush;
    logic                                                 pipe_freeze;
    logic                                                 pc_redirect;
    logic [CNT_W-1:0]                                     perf_stall;
    logic [CNT_W-1:0]                                     perf_flush;

    modport master (
        output id_rs, id_rs_used, id_rd, id_regwrite, id_memread, id_is_branch,
               redirect, icache_stall, dcache_stall,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze, pc_redirect,
               perf_stall, perf_flush
    );

    modport slave (
        input  id_rs, id_rs_used, id_rd, id_regwrite, id_memread, id_is_branch,
               redirect, icache_stall, dcache_stall,
        output pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze, pc_redirect,
               perf_stall, perf_flush
    );

endinterface

// File: rtl/hazard_sb_match.sv
// One scoreboard entry against every ID source operand; flags a still-pending producer.
// Combinational, zero latency; no backpressure.
module hazard_sb_match
    import hazard_scoreboard_ctrl_pkg::*;
#(
    parameter int NUM_SRC      = 2,
    parameter int LOAD_LAT     = 1,
    parameter int BRANCH_IN_ID = 1,
    parameter int IDX          = 0
) (
    input  sb_entry_t                  entry,
    input  logic [NUM_SRC*REG_AW-1:0]  id_rs,
    input  logic [NUM_SRC-1:0]         id_rs_used,
    input  logic                       id_is_branch,
    output logic                       hit
);

    // Cycles still owed by this producer, given that it sits IDX+1 cycles behind ID.
    localparam int REM_ALU = BRANCH_IN_ID - IDX;
    localparam int REM_LD  = LOAD_LAT + BRANCH_IN_ID - IDX;

    logic live;

    assign live = entry.valid &&
                  ((entry.is_load ? REM_LD : REM_ALU) > (id_is_branch ? 0 : BRANCH_IN_ID));

    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_rs_used[k] && (id_rs[k*REG_AW +: REG_AW] != X0) &&
                (id_rs[k*REG_AW +: REG_AW] == entry.rd) && live) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Hazard controller: age-indexed writer scoreboard plus stall/flush/freeze priority mux and perf counters.
// Control outputs are combinational from ID inputs and board state; dcache_stall freezes board and counters.
module hazard_scoreboard_ctrl
    import hazard_scoreboard_ctrl_pkg::*;
#(
    parameter int NUM_SRC      = 2,
    parameter int LOAD_LAT     = 1,
    parameter int BRANCH_IN_ID = 1,
    parameter int CNT_W        = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    hazard_scoreboard_ctrl_if.slave   hz
);

    localparam int D = LOAD_LAT + BRANCH_IN_ID;

    sb_entry_t        sb [D];
    logic [D-1:0]     hit;
    logic             id_hazard;
    logic             frozen;
    logic             redirect_acc;
    logic             issue;
    logic             pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze, pc_redirect;
    logic [CNT_W-1:0] perf_stall_q, perf_flush_q;

    for (genvar i = 0; i < D; i++) begin : g_match
        hazard_sb_match #(
            .NUM_SRC      (NUM_SRC),
            .LOAD_LAT     (LOAD_LAT),
            .BRANCH_IN_ID (BRANCH_IN_ID),
            .IDX          (i)
        ) u_match (
            .entry        (sb[i]),
            .id_rs        (hz.id_rs),
            .id_rs_used   (hz.id_rs_used),
            .id_is_branch (hz.id_is_branch),
            .hit          (hit[i])
        );
    end

    assign id_hazard    = |hit;
    assign frozen       = hz.dcache_stall;
    // A branch resolving in ID must not redirect on operands it is still waiting for.
    assign redirect_acc = hz.redirect & ((BRANCH_IN_ID == 0) | ~id_hazard);

    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_freeze = 1'b0;
        pc_redirect = 1'b0;
        if (rst_n) begin
            if (frozen) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                pipe_freeze = 1'b1;
            end else if (redirect_acc) begin
                pc_redirect = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = (BRANCH_IN_ID == 0);
            end else if (id_hazard) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end else if (hz.icache_stall) begin
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
            end
        end
    end

    assign issue = ~id_hazard & ~id_ex_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) sb[i] <= '0;
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else if (!frozen) begin
            if (issue) begin
                sb[0] <= '{valid:   hz.id_regwrite && (hz.id_rd != X0),
                           rd:      hz.id_rd,
                           is_load: hz.id_memread};
            end else begin
                sb[0] <= '0;
            end
            for (int i = 1; i < D; i++) sb[i] <= sb[i-1];
            if (id_hazard)   perf_stall_q <= perf_stall_q + CNT_W'(1);
            if (pc_redirect) perf_flush_q <= perf_flush_q + CNT_W'(1);
        end
    end

    assign hz.pc_stall    = pc_stall;
    assign hz.if_id_stall = if_id_stall;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_flush = id_ex_flush;
    assign hz.pipe_freeze = pipe_freeze;
    assign hz.pc_redirect = pc_redirect;
    assign hz.perf_stall  = perf_stall_q;
    assign hz.perf_flush  = perf_flush_q;

endmodule
